bit16_add_arbiter: RTL
======================

# bit16_add_arbiter

Round-robin arbiter and sequencer that shares one 16-bit ripple-carry adder (`BIT16_ADDER`) between two requesters. It accepts one operand set at a time through a valid/ready handshake and registers the operands. It gives the ripple chain a full cycle to settle, registers the sum and carry-out, and returns the result to the granted requester through a held response handshake. It sits between the memory-chip datapath clients (address/offset generators) and the single shared adder instance.

## Interface
- No parameters; datapath width fixed at 16 bits.
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid[1:0]`  in  2  per-requester request; held high until accepted
- `req_a0`, `req_b0`  in  16  requester 0 operands
- `req_cin0`  in  1  requester 0 carry-in
- `req_a1`, `req_b1`  in  16  requester 1 operands
- `req_cin1`  in  1  requester 1 carry-in
- `req_ready[1:0]`  out  2  one-hot accept pulse; operands of that requester captured this edge
- `rsp_valid`  out  1  result available; held until `rsp_ready`
- `rsp_id`  out  1  requester owning the current result
- `rsp_sum`  out  16  registered sum
- `rsp_carry`  out  1  registered carry-out
- `rsp_ready`  in  1  response consumer accepts the result
- `busy`  out  1  high in CALC or RESP

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE: if any `req_valid`, grant one requester and assert its `req_ready` bit (combinational from state, valids and pointer). At the edge, capture that requester's a/b/cin into operand registers, record `rsp_id`, update the pointer, and go to CALC. If no request, stay in IDLE.
- Arbitration: pointer `last` holds the last granted id.
  - Single request: grant it.
  - Both requesting: grant `~last`.
  - Reset value `last=1`, so requester 0 wins the first tie.
- CALC: the adder inputs come only from the operand registers. At the edge, load `rsp_sum`/`rsp_carry` from the adder outputs and go to RESP. No requests are accepted.
- RESP: `rsp_valid=1`. Sum, carry and id stay stable. When `rsp_ready=1` at the edge, go to IDLE. Otherwise hold.
- Arithmetic: `{rsp_carry,rsp_sum} = a + b + cin`, modulo 2^17. Overflow wraps into `rsp_carry`; there is no saturation.
- Only one operation is outstanding. `req_ready` is 0 in CALC and RESP.
- Requests are not queued. A requester that drops `req_valid` before its grant is simply not served.
- `req_ready` never has both bits set.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_carry=0`, `busy=0`, state IDLE, `last=1`, operand registers 0.
- Latency: accept at edge N. Result is registered at edge N+1. `rsp_valid` is high in cycle N+1 (after edge N+1).
- Minimum occupancy: 3 cycles per operation, with `rsp_ready` tied high and the next request waiting.
- The first `req_ready` after a response comes in the cycle following the `rsp_ready` handshake; there is no bypass from RESP to accept.
- The full adder chain has one whole cycle (the CALC cycle) to settle. The critical path is operand register → 16-stage ripple → result register.
- Reset mid-operation (in CALC or RESP): the in-flight result is discarded, no response is produced, and all registers return to reset values on that edge.
- If `rst` and `req_valid` are both high, reset wins and nothing is granted.
- Changes on `req_*` during CALC/RESP have no effect on the current result.

## Test plan
- Reset, then `req_valid=01`, a0=0x1234, b0=0x4321, cin0=0 → `req_ready=01` in the same cycle. Two edges later: `rsp_valid=1`, `rsp_id=0`, `rsp_sum=0x5555`, `rsp_carry=0`.
- Overflow: req1 a=0xFFFF, b=0x0001, cin=1 → `rsp_sum=0x0001`, `rsp_carry=1`, `rsp_id=1`.
- Tie and fairness: `req_valid=11` held for four operations, `rsp_ready=1` → grant order 0,1,0,1. Each response carries the matching operands' sum. `req_ready` is never 11.
- Backpressure: `rsp_ready=0` for 5 cycles in RESP with the other requester valid → outputs stable, `req_ready=00`, `busy=1`. After `rsp_ready=1`: IDLE, then the pending requester is granted the next cycle.
- Reset mid-op: assert `rst` in the CALC cycle → next cycle all outputs are 0, `rsp_valid` never asserts, and the next tie grants requester 0.
- Random: 1000 randomized requests with random `rsp_ready` → every sum/carry matches the model `a+b+cin` for the recorded id, and no request is dropped while it is held valid.

Source files
------------

// File: rtl/bit16_add_arbiter.sv
// Two-requester round-robin front end for one shared 16-bit ripple-carry adder.
// Accepts one operand set at a time and gives the ripple chain a full cycle to settle.

module bit16_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module bit16_ripple_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [16:0] c;

  assign c[0] = cin;
  bit16_full_adder u_fa [15:0] (
    .a  (a),
    .b  (b),
    .ci (c[15:0]),
    .s  (sum),
    .co (c[16:1])
  );
  assign cout = c[16];
endmodule

module bit16_add_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_a0,
  input  logic [15:0] req_b0,
  input  logic        req_cin0,
  input  logic [15:0] req_a1,
  input  logic [15:0] req_b1,
  input  logic        req_cin1,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_sum,
  output logic        rsp_carry,
  input  logic        rsp_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic        op_cin_q, op_cin_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_sum_q, rsp_sum_d;
  logic        rsp_carry_q, rsp_carry_d;

  logic        gnt_id;
  logic        accept;
  logic [15:0] add_sum;
  logic        add_cout;

  // Adder sees only the operand registers, so the whole CALC cycle is available to it.
  bit16_ripple_adder u_add (
    .a    (op_a_q),
    .b    (op_b_q),
    .cin  (op_cin_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // On a tie, the requester not served last wins; a lone request always wins.
  always_comb begin
    gnt_id = req_valid[1];
    if (&req_valid) gnt_id = ~last_q;
  end

  // Reset gates the grant so nothing is captured on a reset edge.
  assign accept    = (state_q == IDLE) && (|req_valid) && !rst;
  assign req_ready = accept ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d   = gnt_id ? req_a1   : req_a0;
          op_b_d   = gnt_id ? req_b1   : req_b0;
          op_cin_d = gnt_id ? req_cin1 : req_cin0;
          rsp_id_d = gnt_id;
          last_d   = gnt_id;
          state_d  = CALC;
        end
      end
      CALC: begin
        rsp_sum_d   = add_sum;
        rsp_carry_d = add_cout;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign busy      = (state_q != IDLE);
endmodule
